// File: rtl/adder.sv
// Byte-serial adder: one CHUNK-bit slice of each operand per clock, LS slice first.
// The full WIDTH-bit sum and carry-out are published on the last beat and held until the next word completes.
module adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             TClk,
  input  logic             TRstN,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic             cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned BEATS  = WIDTH / CHUNK;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SLICE_W = CHUNK + 1;

  logic [BEAT_W-1:0] beat;
  logic              carry;
  logic [WIDTH-1:0]  partial;

  logic              last_beat_c;
  logic              ci_c;
  logic [CHUNK:0]    slice_sum_c;
  logic [WIDTH-1:0]  partial_next_c;

  // Slice add; word carry-in enters only on beat 0
  always_comb begin
    last_beat_c    = (beat == BEAT_W'(BEATS - 1));
    ci_c           = (beat == '0) ? cin : carry;
    slice_sum_c    = SLICE_W'(ra[CHUNK-1:0]) + SLICE_W'(rb[CHUNK-1:0]) + SLICE_W'(ci_c);
    partial_next_c = partial;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat == BEAT_W'(i)) begin
        partial_next_c[i*CHUNK +: CHUNK] = slice_sum_c[CHUNK-1:0];
      end
    end
  end

  // Free-running beat counter, slice accumulation and result publication
  always_ff @(posedge TClk or negedge TRstN) begin
    if (!TRstN) begin
      beat    <= '0;
      carry   <= 1'b0;
      partial <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      carry   <= slice_sum_c[CHUNK];
      partial <= partial_next_c;
      if (last_beat_c) begin
        beat <= '0;
        Sum  <= partial_next_c;
        Cout <= slice_sum_c[CHUNK];
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Randomized self-checking bench for the byte-serial adder.
// Expected results come from whole-word arithmetic on the assembled operands.
module tb_adder;

  localparam int unsigned W     = 32;
  localparam int unsigned C     = 8;
  localparam int unsigned BEATS = W / C;

  logic         TClk = 1'b0;
  logic         TRstN;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         cin;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_cmp = 0;
  int n_err = 0;

  // Last completed result the design should be holding: {Cout, Sum}
  logic [W:0] model_q;

  adder #(.WIDTH(W), .CHUNK(C)) dut (
    .TClk  (TClk),
    .TRstN (TRstN),
    .ra    (ra),
    .rb    (rb),
    .cin   (cin),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 TClk = ~TClk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Drive one word slice by slice; record outputs seen after the first BEATS-1 edges
  task automatic feed_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [BEATS-1:0] cpat, input bit junk,
                           output logic [BEATS-2:0][W:0] mid);
    logic [31:0] r1, r2;
    for (int k = 0; k < int'(BEATS); k++) begin
      r1  = $urandom;
      r2  = $urandom;
      ra  = junk ? {r1[W-1:C], a[k*C +: C]} : W'(a[k*C +: C]);
      rb  = junk ? {r2[W-1:C], b[k*C +: C]} : W'(b[k*C +: C]);
      cin = cpat[k];
      @(posedge TClk);
      #1;
      if (k < int'(BEATS) - 1) mid[k] = {Cout, Sum};
    end
  endtask

  task automatic test_reset;
    TRstN = 1'b0;
    ra = '0; rb = '0; cin = 1'b0;
    #12;
    n_cmp++;
    if ({Cout, Sum} !== '0) begin
      n_err++;
      $display("FAIL reset_init: got %h expected %h", {Cout, Sum}, (W+1)'(0));
    end
    @(posedge TClk);
    #1;
    TRstN   = 1'b1;
    model_q = '0;
  endtask

  task automatic test_basic;
    logic [BEATS-2:0][W:0] mid;
    logic [W:0] exp;
    feed_word(32'h1234_5678, 32'h1111_1111, 4'b0000, 1'b0, mid);
    for (int k = 0; k < int'(BEATS) - 1; k++) begin
      n_cmp++;
      if (mid[k] !== model_q) begin
        n_err++;
        $display("FAIL basic_hold%0d: got %h expected %h", k, mid[k], model_q);
      end
    end
    exp = ref_add(32'h1234_5678, 32'h1111_1111, 1'b0);
    n_cmp++;
    if ({Cout, Sum} !== exp || exp !== 33'h0_2345_6789) begin
      n_err++;
      $display("FAIL basic_sum: got %h expected %h", {Cout, Sum}, 33'h0_2345_6789);
    end
    model_q = exp;
  endtask

  task automatic test_carry_chain;
    logic [BEATS-2:0][W:0] mid;
    feed_word(32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 1'b0, mid);
    n_cmp++;
    if ({Cout, Sum} !== 33'h1_0000_0000) begin
      n_err++;
      $display("FAIL chain_b1: got %h expected %h", {Cout, Sum}, 33'h1_0000_0000);
    end
    n_cmp++;
    if (mid[BEATS-2] !== model_q) begin
      n_err++;
      $display("FAIL chain_hold: got %h expected %h", mid[BEATS-2], model_q);
    end
    model_q = ref_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    feed_word(32'hFFFF_FFFF, 32'h0000_0000, 4'b0001, 1'b0, mid);
    n_cmp++;
    if ({Cout, Sum} !== ref_add(32'hFFFF_FFFF, 32'h0, 1'b1)) begin
      n_err++;
      $display("FAIL chain_cin: got %h expected %h", {Cout, Sum}, ref_add(32'hFFFF_FFFF, 32'h0, 1'b1));
    end
    model_q = ref_add(32'hFFFF_FFFF, 32'h0, 1'b1);
  endtask

  task automatic test_cin;
    logic [BEATS-2:0][W:0] mid;
    feed_word('0, '0, 4'b1110, 1'b0, mid);
    n_cmp++;
    if ({Cout, Sum} !== (W+1)'(0)) begin
      n_err++;
      $display("FAIL cin_late_ignored: got %h expected %h", {Cout, Sum}, (W+1)'(0));
    end
    feed_word('0, '0, 4'b0001, 1'b0, mid);
    n_cmp++;
    if ({Cout, Sum} !== (W+1)'(1)) begin
      n_err++;
      $display("FAIL cin_beat0: got %h expected %h", {Cout, Sum}, (W+1)'(1));
    end
    model_q = (W+1)'(1);
  endtask

  task automatic test_masking;
    logic [W:0] exp;
    exp = ref_add(32'h0101_0101, 32'h0202_0202, 1'b0);
    for (int k = 0; k < int'(BEATS); k++) begin
      ra  = 32'hABCD_EF01;
      rb  = 32'h55AA_5502;
      cin = 1'b0;
      @(posedge TClk);
      #1;
    end
    n_cmp++;
    if ({Cout, Sum} !== exp) begin
      n_err++;
      $display("FAIL mask: got %h expected %h", {Cout, Sum}, exp);
    end
    model_q = exp;
  endtask

  task automatic test_midword_reset;
    logic [BEATS-2:0][W:0] mid;
    logic [W-1:0] a, b;
    logic [W:0] exp;
    for (int k = 0; k < 2; k++) begin
      ra = 32'h0000_00C3; rb = 32'h0000_0077; cin = 1'b1;
      @(posedge TClk);
      #1;
    end
    TRstN = 1'b0;
    #1;
    n_cmp++;
    if ({Cout, Sum} !== (W+1)'(0)) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", {Cout, Sum}, (W+1)'(0));
    end
    #2;
    TRstN   = 1'b1;
    model_q = '0;
    a = $urandom;
    b = $urandom;
    feed_word(a, b, 4'b0000, 1'b1, mid);
    n_cmp++;
    if (mid[0] !== model_q) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", mid[0], model_q);
    end
    exp = ref_add(a, b, 1'b0);
    n_cmp++;
    if ({Cout, Sum} !== exp) begin
      n_err++;
      $display("FAIL reset_fresh_word: got %h expected %h", {Cout, Sum}, exp);
    end
    model_q = exp;
  endtask

  task automatic test_back_to_back;
    logic [BEATS-2:0][W:0] mid;
    logic [W-1:0] a, b;
    logic [31:0] r;
    logic [W:0] exp;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = $urandom;
      r = $urandom;
      if (n == 0) begin a = 32'hFFFF_FFFF; b = $urandom | 32'h1; end
      feed_word(a, b, r[BEATS-1:0], 1'b1, mid);
      for (int k = 0; k < int'(BEATS) - 1; k++) begin
        n_cmp++;
        if (mid[k] !== model_q) begin
          n_err++;
          $display("FAIL b2b_hold%0d_%0d: got %h expected %h", n, k, mid[k], model_q);
        end
      end
      exp = ref_add(a, b, r[0]);
      n_cmp++;
      if ({Cout, Sum} !== exp) begin
        n_err++;
        $display("FAIL b2b_word%0d: a=%h b=%h cin=%b got %h expected %h", n, a, b, r[0], {Cout, Sum}, exp);
      end
      model_q = exp;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry_chain;
    test_cin;
    test_masking;
    test_midword_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
